// File: rtl/cute_lock_pkg.sv
// rtl/cute_lock_pkg.sv - shared state type, default sizes and helpers for the Cute-Lock key sequencer
//
// Contents:
//   keyseq_state_e    sequencer FSM states {IDLE, LOAD, READY, RUN}
//   KEYSEQ_KEY_W      default key / keyinput bus width
//   KEYSEQ_NUM_KEYS   default keys per period
//   KEYSEQ_WIN_LEN    default clock cycles per key window
//   idx_width()       index width that never collapses to zero bits
package cute_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } keyseq_state_e;

    localparam int unsigned KEYSEQ_KEY_W    = 7;
    localparam int unsigned KEYSEQ_NUM_KEYS = 2;
    localparam int unsigned KEYSEQ_WIN_LEN  = 4;

    // $clog2 yields 0 for n<=1, which would produce zero-width vectors.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keyseq_shift_loader.sv
// rtl/keyseq_shift_loader.sv - serial key store: shift register, bit counter and done flag
//
// Ports:
//   clk         in   clock, posedge
//   rst_n       in   asynchronous active-low reset
//   shift_en_i  in   shift sdi_i into the store this edge (ignored once full)
//   sdi_i       in   serial data; first bit shifted ends up in the store MSB
//   clear_i     in   synchronous clear of store, counter and done flag (wins over shift)
//   store_o     out  TOTAL_W-bit key store, key0 in the top KEY_W bits
//   at_last_o   out  counter is waiting for the final bit
//   done_o      out  all TOTAL_W bits have been loaded
module keyseq_shift_loader
    import cute_lock_pkg::*;
#(
    parameter int unsigned TOTAL_W = KEYSEQ_KEY_W * KEYSEQ_NUM_KEYS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en_i,
    input  logic               sdi_i,
    input  logic               clear_i,
    output logic [TOTAL_W-1:0] store_o,
    output logic               at_last_o,
    output logic               done_o
);

    localparam int unsigned CNT_W = idx_width(TOTAL_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_W - 1);

    logic [TOTAL_W-1:0] store_q, store_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               done_q, done_d;

    assign store_o   = store_q;
    assign done_o    = done_q;
    assign at_last_o = !done_q && (bit_cnt_q == LAST_CNT);

    always_comb begin
        store_d   = store_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        if (clear_i) begin
            store_d   = '0;
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end else if (shift_en_i && !done_q) begin
            // Shift toward the MSB so the first bit received lands in key0[MSB].
            store_d   = (store_q << 1) | TOTAL_W'(sdi_i);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_CNT) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            store_q   <= store_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: rtl/cute_key_sequencer.sv
// rtl/cute_key_sequencer.sv - key-side sequencer driving a Cute-Lock time-varying locked FSM
//
// Build option: KEYSEQ_ZEROIZE_EN - when defined, dropping arm in RUN wipes the key store and
// returns to IDLE (keys must be reloaded); otherwise keys are kept and the FSM returns to READY.
//
// Ports:
//   clk        in   single clock; the locked FSM samples key_out on negedge
//   rst_n      in   asynchronous active-low reset
//   load_en    in   serial load strobe (level, sampled on posedge)
//   load_sdi   in   serial key data, key0 MSB first
//   load_done  out  all NUM_KEYS*KEY_W bits loaded
//   arm        in   run the key sequence while high
//   armed      out  sequencer is in RUN
//   tgt_rst    out  active-high reset to the locked FSM
//   key_out    out  keyinput bus to the locked FSM
//   slot_idx   out  index of the key currently driven
module cute_key_sequencer
    import cute_lock_pkg::*;
#(
    parameter int unsigned KEY_W    = KEYSEQ_KEY_W,
    parameter int unsigned NUM_KEYS = KEYSEQ_NUM_KEYS,
    parameter int unsigned WIN_LEN  = KEYSEQ_WIN_LEN
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_en,
    input  logic                              load_sdi,
    output logic                              load_done,
    input  logic                              arm,
    output logic                              armed,
    output logic                              tgt_rst,
    output logic [KEY_W-1:0]                  key_out,
    output logic [idx_width(NUM_KEYS)-1:0]    slot_idx
);

    localparam int unsigned TOTAL_W = NUM_KEYS * KEY_W;
    localparam int unsigned PERIOD  = NUM_KEYS * WIN_LEN;
    localparam int unsigned CNT_W   = idx_width(PERIOD);
    localparam int unsigned SLOT_W  = idx_width(NUM_KEYS);

    keyseq_state_e state_q, state_d;

    logic               tgt_rst_q, tgt_rst_d;
    logic               armed_q, armed_d;
    logic [KEY_W-1:0]   key_out_q, key_out_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               ld_shift;
    logic               ld_clear;
    logic [TOTAL_W-1:0] ld_store;
    logic               ld_at_last;
    logic               ld_done;

    logic [SLOT_W-1:0]  cur_slot;
    logic [KEY_W-1:0]   key_sel;
    logic [KEY_W-1:0]   key0;

    keyseq_shift_loader #(
        .TOTAL_W (TOTAL_W)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (ld_shift),
        .sdi_i      (load_sdi),
        .clear_i    (ld_clear),
        .store_o    (ld_store),
        .at_last_o  (ld_at_last),
        .done_o     (ld_done)
    );

    // Window counter mirrors the locked FSM's own counter: both start at 0 when tgt_rst
    // is released and advance on the negedge, so cnt_q always names the window that the
    // next negedge will consume.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            cnt_q <= (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign cur_slot = SLOT_W'(32'(cnt_q) / WIN_LEN);
    assign key0     = ld_store[TOTAL_W-1 -: KEY_W];

    always_comb begin
        key_sel = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (cur_slot == SLOT_W'(i)) begin
                key_sel = ld_store[TOTAL_W - 1 - i * KEY_W -: KEY_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tgt_rst_d = tgt_rst_q;
        armed_d   = armed_q;
        key_out_d = key_out_q;
        slot_d    = slot_q;
        ld_shift  = 1'b0;
        ld_clear  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    ld_shift = 1'b1;
                    state_d  = ld_at_last ? ST_READY : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_en) begin
                    ld_shift = 1'b1;
                    if (ld_at_last) begin
                        state_d = ST_READY;
                    end
                end else begin
                    // A broken stream leaves a partial key set; discard it entirely.
                    ld_clear = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_READY: begin
                // load_en is deliberately ignored here, so arm always wins a tie.
                if (arm) begin
                    state_d   = ST_RUN;
                    tgt_rst_d = 1'b0;
                    armed_d   = 1'b1;
                    key_out_d = key0;
                    slot_d    = '0;
                end
            end
            ST_RUN: begin
                if (!arm) begin
                    tgt_rst_d = 1'b1;
                    armed_d   = 1'b0;
                    key_out_d = '0;
                    slot_d    = '0;
`ifdef KEYSEQ_ZEROIZE_EN
                    ld_clear  = 1'b1;
                    state_d   = ST_IDLE;
`else
                    state_d   = ST_READY;
`endif
                end else begin
                    // Updated on posedge so the key settles half a cycle before the
                    // negedge that consumes cnt_q.
                    key_out_d = key_sel;
                    slot_d    = cur_slot;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tgt_rst_q <= 1'b1;
            armed_q   <= 1'b0;
            key_out_q <= '0;
            slot_q    <= '0;
        end else begin
            state_q   <= state_d;
            tgt_rst_q <= tgt_rst_d;
            armed_q   <= armed_d;
            key_out_q <= key_out_d;
            slot_q    <= slot_d;
        end
    end

    assign load_done = ld_done;
    assign armed     = armed_q;
    assign tgt_rst   = tgt_rst_q;
    assign key_out   = key_out_q;
    assign slot_idx  = slot_q;

endmodule

// File: tb/tb_cute_key_sequencer.sv
// tb/tb_cute_key_sequencer.sv - self-checking bench for cute_key_sequencer
module tb_cute_key_sequencer;

    localparam int KW     = 7;
    localparam int NK     = 2;
    localparam int WL     = 4;
    localparam int TOTAL  = NK * KW;
    localparam int PERIOD = NK * WL;

    logic          clk;
    logic          rst_n;
    logic          load_en;
    logic          load_sdi;
    logic          load_done;
    logic          arm;
    logic          armed;
    logic          tgt_rst;
    logic [KW-1:0] key_out;
    logic [0:0]    slot_idx;

    int n_checks;
    int n_pass;

    logic [KW-1:0] mkey [NK];
    int            win;

    cute_key_sequencer #(
        .KEY_W    (KW),
        .NUM_KEYS (NK),
        .WIN_LEN  (WL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_sdi  (load_sdi),
        .load_done (load_done),
        .arm       (arm),
        .armed     (armed),
        .tgt_rst   (tgt_rst),
        .key_out   (key_out),
        .slot_idx  (slot_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, ".tgt_rst"},   32'(tgt_rst),   32'd1);
        check({tag, ".armed"},     32'(armed),     32'd0);
        check({tag, ".key_out"},   32'(key_out),   32'd0);
        check({tag, ".slot_idx"},  32'(slot_idx),  32'd0);
        check({tag, ".load_done"}, 32'(load_done), 32'd0);
    endtask

    task automatic apply_reset();
        arm     = 1'b0;
        load_en = 1'b0;
        rst_n   = 1'b0;
        #3;
        expect_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Key i is the i-th KW-bit field of the stream, counting from the first bit sent.
    task automatic set_keys(input logic [TOTAL-1:0] data);
        for (int i = 0; i < NK; i++) begin
            mkey[i] = KW'(data >> ((NK - 1 - i) * KW));
        end
    endtask

    // Stream the first nbits of data (MSB first) starting from IDLE with an empty store.
    task automatic load_stream(input logic [TOTAL-1:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            load_en  = 1'b1;
            load_sdi = data[TOTAL - 1 - i];
            @(posedge clk);
            #1;
            check("load_done_during_load", 32'(load_done), (i == TOTAL - 1) ? 32'd1 : 32'd0);
        end
        load_en = 1'b0;
        @(posedge clk);
        #1;
        check("load_done_after_load", 32'(load_done), (nbits == TOTAL) ? 32'd1 : 32'd0);
        check("tgt_rst_while_loading", 32'(tgt_rst), 32'd1);
    endtask

    task automatic arm_start();
        arm = 1'b1;
        check("tgt_rst_before_arm_edge", 32'(tgt_rst), 32'd1);
        @(posedge clk);
        #1;
        check("tgt_rst_after_arm", 32'(tgt_rst), 32'd0);
        check("armed_after_arm", 32'(armed), 32'd1);
        win = 0;
    endtask

    // The locked FSM consumes window (win mod PERIOD) at every negedge after release.
    task automatic run_negedges(input int n);
        int slot;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            slot = (win % PERIOD) / WL;
            check("key_at_negedge", 32'(key_out), 32'(mkey[slot]));
            check("slot_at_negedge", 32'(slot_idx), 32'(slot));
            check("tgt_rst_in_run", 32'(tgt_rst), 32'd0);
            win++;
        end
    endtask

    task automatic disarm();
        arm = 1'b0;
        @(posedge clk);
        #1;
        check("disarm.tgt_rst", 32'(tgt_rst), 32'd1);
        check("disarm.armed", 32'(armed), 32'd0);
        check("disarm.key_out", 32'(key_out), 32'd0);
        check("disarm.slot_idx", 32'(slot_idx), 32'd0);
`ifdef KEYSEQ_ZEROIZE_EN
        check("disarm.load_done", 32'(load_done), 32'd0);
`else
        check("disarm.load_done", 32'(load_done), 32'd1);
`endif
    endtask

    // After an abort the sequencer must either restart from key0 or refuse to run.
    task automatic rearm_after_abort();
`ifdef KEYSEQ_ZEROIZE_EN
        arm = 1'b1;
        @(posedge clk);
        #1;
        check("zeroize.no_rearm.armed", 32'(armed), 32'd0);
        check("zeroize.no_rearm.tgt_rst", 32'(tgt_rst), 32'd1);
        arm = 1'b0;
        @(posedge clk);
        #1;
`else
        arm_start();
        run_negedges(PERIOD + 2);
        disarm();
`endif
    endtask

    initial begin
        logic [TOTAL-1:0] data;
        logic [TOTAL-1:0] directed;
        n_checks = 0;
        n_pass   = 0;
        win      = 0;
        rst_n    = 1'b0;
        load_en  = 1'b0;
        load_sdi = 1'b0;
        arm      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_reset_outputs("power_on");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed stream: key0 = 73, key1 = 74.
        directed = 14'b1001001_1001010;
        load_stream(directed, TOTAL);
        set_keys(directed);
        arm_start();
        run_negedges(3 * PERIOD);
        // Drop arm after window 5 has been consumed.
        run_negedges(6);
        disarm();
        rearm_after_abort();

        // Aborted partial load, then a full reload.
        apply_reset();
        data = TOTAL'($urandom);
        load_stream(data, 9);
        arm = 1'b1;
        @(posedge clk);
        #1;
        check("partial_load.no_arm", 32'(armed), 32'd0);
        arm = 1'b0;
        data = TOTAL'($urandom);
        load_stream(data, TOTAL);
        set_keys(data);

        // arm and load_en together in READY: arm wins, stored keys untouched.
        load_en  = 1'b1;
        load_sdi = ~data[0];
        arm_start();
        run_negedges(PERIOD + 3);
        load_en = 1'b0;
        disarm();

        // Asynchronous reset in the middle of RUN.
        apply_reset();
        data = TOTAL'($urandom);
        load_stream(data, TOTAL);
        set_keys(data);
        arm_start();
        run_negedges(5);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset_outputs("async_reset_in_run");
        arm = 1'b0;
        #1;
        rst_n = 1'b1;

        // Randomised sessions.
        for (int iter = 0; iter < 8; iter++) begin
            apply_reset();
            if ($urandom_range(0, 2) == 0) begin
                load_stream(TOTAL'($urandom), $urandom_range(1, TOTAL - 1));
            end
            data = TOTAL'($urandom);
            load_stream(data, TOTAL);
            set_keys(data);
            arm_start();
            run_negedges($urandom_range(1, 3 * PERIOD));
            disarm();
            if ($urandom_range(0, 1) == 1) begin
                rearm_after_abort();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
